// File: rtl/m68k_bus_target.sv
// m68k_bus_target: 68000 bus responder for a 16-byte register window, terminated with DTACK after WAIT_STATES sys_clk cycles.
// Define M68K_TARGET_BERR_EN to end writes to the read-only ID register (index 7) with BERR instead of DTACK.
module m68k_bus_target #(
    parameter logic [23:0] BASE_ADDR   = 24'hE90000,
    parameter int unsigned WAIT_STATES = 4,
    parameter logic [15:0] ID_VALUE    = 16'h5016
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [23:1] A_IN,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic        nAS_IN,
    input  logic        nUDS_IN,
    input  logic        nLDS_IN,
    input  logic        RnW_IN,
    output logic        nDTACK_OE,
    output logic        nBERR_OE,
    output logic        wr_pulse,
    output logic [2:0]  wr_index,
    output logic [15:0] wr_data
);
    typedef enum logic [2:0] {S_IDLE, S_IGNORE, S_DECODE, S_WAIT, S_ACK, S_HOLD} state_t;
    state_t      state, state_n;
    logic [1:0]  as_sync, uds_sync, lds_sync, rnw_sync;
    logic        as_n, uds_n, lds_n, rnw_s;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic        rnw, rnw_n;
    logic        d_oe_n, dtack_n, berr_n, pulse_n, wr_en;
    logic [15:0] d_out_n, wr_val, rd_data;
    logic [15:0] regs [8];
    logic        hit, ack_berr;

    assign as_n    = as_sync[1];
    assign uds_n   = uds_sync[1];
    assign lds_n   = lds_sync[1];
    assign rnw_s   = rnw_sync[1];
    assign hit     = A_IN[23:4] == BASE_ADDR[23:4];
    assign rd_data = (A_IN[3:1] == 3'd7) ? ID_VALUE : regs[A_IN[3:1]];
    assign wr_val  = {uds_n ? regs[idx][15:8] : D_IN[15:8], lds_n ? regs[idx][7:0] : D_IN[7:0]};
`ifdef M68K_TARGET_BERR_EN
    assign ack_berr = !rnw && idx == 3'd7;
`else
    assign ack_berr = 1'b0;
`endif

    // Strobes idle high, so the synchronizers reset to the released level.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            as_sync  <= 2'b11;
            uds_sync <= 2'b11;
            lds_sync <= 2'b11;
            rnw_sync <= 2'b11;
        end else begin
            as_sync  <= {as_sync[0], nAS_IN};
            uds_sync <= {uds_sync[0], nUDS_IN};
            lds_sync <= {lds_sync[0], nLDS_IN};
            rnw_sync <= {rnw_sync[0], RnW_IN};
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            rnw       <= 1'b1;
            D_OUT     <= '0;
            D_OE      <= 1'b0;
            nDTACK_OE <= 1'b0;
            nBERR_OE  <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            rnw       <= rnw_n;
            D_OUT     <= d_out_n;
            D_OE      <= d_oe_n;
            nDTACK_OE <= dtack_n;
            nBERR_OE  <= berr_n;
            wr_pulse  <= pulse_n;
            if (wr_en) begin
                regs[idx] <= wr_val;
                wr_index  <= idx;
                wr_data   <= wr_val;
            end
        end
    end

    // Read data is driven from the decode edge so it settles well before DTACK.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        rnw_n   = rnw;
        d_out_n = D_OUT;
        d_oe_n  = D_OE;
        dtack_n = nDTACK_OE;
        berr_n  = nBERR_OE;
        pulse_n = 1'b0;
        wr_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!as_n) begin
                    state_n = hit ? S_DECODE : S_IGNORE;
                    idx_n   = A_IN[3:1];
                    rnw_n   = rnw_s;
                    d_oe_n  = hit && rnw_s;
                    d_out_n = (hit && rnw_s) ? rd_data : D_OUT;
                end
            end
            S_IGNORE: state_n = as_n ? S_IDLE : S_IGNORE;
            S_DECODE: begin
                cnt_n   = 4'(WAIT_STATES);
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (as_n) begin
                    state_n = S_IDLE;
                    d_oe_n  = 1'b0;
                end else if (cnt <= 4'd1) begin
                    state_n = S_ACK;
                    dtack_n = !ack_berr;
                    berr_n  = ack_berr;
                    wr_en   = !rnw && idx != 3'd7 && !(uds_n && lds_n);
                    pulse_n = wr_en;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_ACK: state_n = S_HOLD;
            S_HOLD: begin
                if (as_n) begin
                    state_n = S_IDLE;
                    d_oe_n  = 1'b0;
                    dtack_n = 1'b0;
                    berr_n  = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_m68k_bus_target.sv
// tb_m68k_bus_target: directed bus cycles against m68k_bus_target; expectations queued at issue, checked by a monitor on each termination.
module tb_m68k_bus_target;
    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [23:1] A_IN    = '0;
    logic [15:0] D_IN    = '0;
    logic        nAS_IN  = 1'b1;
    logic        nUDS_IN = 1'b1;
    logic        nLDS_IN = 1'b1;
    logic        RnW_IN  = 1'b1;
    logic [15:0] D_OUT;
    logic        D_OE, nDTACK_OE, nBERR_OE, wr_pulse;
    logic [2:0]  wr_index;
    logic [15:0] wr_data;

    m68k_bus_target dut (
        .sys_clk(sys_clk), .reset(reset), .A_IN(A_IN), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
        .nAS_IN(nAS_IN), .nUDS_IN(nUDS_IN), .nLDS_IN(nLDS_IN), .RnW_IN(RnW_IN),
        .nDTACK_OE(nDTACK_OE), .nBERR_OE(nBERR_OE), .wr_pulse(wr_pulse),
        .wr_index(wr_index), .wr_data(wr_data)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          berr;
        bit          rd;
        logic [15:0] data;
        bit          pulse;
        logic [2:0]  widx;
        logic [15:0] wdata;
        int          fall;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    int   ack_cnt = 0, doe_cnt = 0, doe_cyc = 0, rise_cyc = 0;
    bit   ack_prev = 0, doe_prev = 0, pulse_chk = 0, in_reset = 0;
    logic ack;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input bit berr, input bit rd, input logic [15:0] data, input bit pulse,
                                input logic [2:0] widx, input logic [15:0] wdata);
        exp_t e;
        e.berr = berr; e.rd = rd; e.data = data; e.pulse = pulse;
        e.widx = widx; e.wdata = wdata; e.fall = 0;
        return e;
    endfunction

    always @(negedge sys_clk) begin
        ack = nDTACK_OE | nBERR_OE;
        if (pulse_chk) begin
            check("wr_pulse_width", {31'd0, wr_pulse}, 0);
            pulse_chk = 0;
        end
        if (D_OE && !doe_prev) begin
            doe_cnt++;
            doe_cyc = cyc;
        end
        if (ack && !ack_prev) begin
            ack_cnt++;
            pulse_chk = 1;
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got termination at cycle %0d, expected none", cyc);
            end else begin
                m = q.pop_front();
                check("ack_latency", cyc - m.fall, 8);
                check("dtack", {31'd0, nDTACK_OE}, {31'd0, !m.berr});
                check("berr", {31'd0, nBERR_OE}, {31'd0, m.berr});
                check("wr_pulse", {31'd0, wr_pulse}, {31'd0, m.pulse});
                check("wr_index", {29'd0, wr_index}, {29'd0, m.widx});
                check("wr_data", {16'd0, wr_data}, {16'd0, m.wdata});
                check("d_oe", {31'd0, D_OE}, {31'd0, m.rd});
                if (m.rd) begin
                    check("d_out", {16'd0, D_OUT}, {16'd0, m.data});
                    check("doe_lead", cyc - doe_cyc, 5);
                end
            end
        end
        if (!ack && ack_prev && !in_reset) begin
            check("release_latency", cyc - rise_cyc, 3);
            check("doe_release", {31'd0, D_OE}, 0);
        end
        ack_prev = ack;
        doe_prev = D_OE;
    end

    task automatic bus(input logic [23:0] addr, input bit rnw, input bit uds_n, input bit lds_n,
                       input logic [15:0] din, input bit acked, input int abort_after, input exp_t e);
        int a0, d0, n;
        @(posedge sys_clk); #1;
        A_IN = addr[23:1]; D_IN = din; RnW_IN = rnw;
        nUDS_IN = uds_n; nLDS_IN = lds_n; nAS_IN = 1'b0;
        a0 = ack_cnt;
        d0 = doe_cnt;
        if (acked) begin
            e.fall = cyc;
            q.push_back(e);
            n = 0;
            while (ack_cnt == a0 && n < 40) begin
                @(posedge sys_clk);
                n++;
            end
            if (n >= 40) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_timeout: got no termination for %06h, expected one", addr);
            end
            repeat (2) @(posedge sys_clk);
        end else begin
            repeat (abort_after > 0 ? abort_after : 15) @(posedge sys_clk);
        end
        #1;
        nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1; RnW_IN = 1'b1;
        rise_cyc = cyc;
        repeat (6) @(posedge sys_clk);
        if (!acked) begin
            check("no_ack", ack_cnt - a0, 0);
            check("no_doe", doe_cnt - d0, 0);
        end
    endtask

    localparam bit BERR_BUILD =
`ifdef M68K_TARGET_BERR_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        int a0, n;
        exp_t none;
        none = mk(0, 0, 16'h0, 0, 3'd0, 16'h0);
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_d_oe", {31'd0, D_OE}, 0);
        check("rst_dtack", {31'd0, nDTACK_OE}, 0);
        check("rst_berr", {31'd0, nBERR_OE}, 0);
        check("rst_wr_pulse", {31'd0, wr_pulse}, 0);
        check("rst_wr_index", {29'd0, wr_index}, 0);
        check("rst_wr_data", {16'd0, wr_data}, 0);
        check("rst_d_out", {16'd0, D_OUT}, 0);
        reset = 1'b0;
        repeat (2) @(posedge sys_clk);

        bus(24'hE90002, 0, 0, 0, 16'hA55A, 1, 0, mk(0, 0, 16'h0, 1, 3'd1, 16'hA55A));
        bus(24'hE90002, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'hA55A, 0, 3'd1, 16'hA55A));
        bus(24'hE90004, 0, 0, 0, 16'h1122, 1, 0, mk(0, 0, 16'h0, 1, 3'd2, 16'h1122));
        bus(24'hE90004, 0, 1, 0, 16'hFF3C, 1, 0, mk(0, 0, 16'h0, 1, 3'd2, 16'h113C));
        bus(24'hE90004, 0, 0, 1, 16'h77FF, 1, 0, mk(0, 0, 16'h0, 1, 3'd2, 16'h773C));
        bus(24'hE90004, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'h773C, 0, 3'd2, 16'h773C));
        bus(24'hE9000E, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'h5016, 0, 3'd2, 16'h773C));
        bus(24'hE90010, 1, 0, 0, 16'h0, 0, 0, none);
        bus(24'h000000, 0, 0, 0, 16'hDEAD, 0, 0, none);
        bus(24'hE90002, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'hA55A, 0, 3'd2, 16'h773C));
        bus(24'hE90006, 0, 1, 1, 16'h5555, 1, 0, mk(0, 0, 16'h0, 0, 3'd2, 16'h773C));
        bus(24'hE90006, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'h0000, 0, 3'd2, 16'h773C));
        bus(24'hE9000E, 0, 0, 0, 16'h1234, 1, 0, mk(BERR_BUILD, 0, 16'h0, 0, 3'd2, 16'h773C));
        bus(24'hE9000E, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'h5016, 0, 3'd2, 16'h773C));
        bus(24'hE90006, 0, 0, 0, 16'hBEEF, 0, 4, none);
        bus(24'hE90006, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'h0000, 0, 3'd2, 16'h773C));

        // Reset while the target holds DTACK and read data on the bus.
        @(posedge sys_clk); #1;
        A_IN = 23'(24'hE90002 >> 1); RnW_IN = 1'b1; nUDS_IN = 1'b0; nLDS_IN = 1'b0; nAS_IN = 1'b0;
        m = mk(0, 1, 16'hA55A, 0, 3'd2, 16'h773C);
        m.fall = cyc;
        q.push_back(m);
        a0 = ack_cnt;
        n = 0;
        while (ack_cnt == a0 && n < 40) begin
            @(posedge sys_clk);
            n++;
        end
        check("hold_ack_seen", {31'd0, ack_cnt != a0}, 1);
        repeat (2) @(posedge sys_clk);
        #3;
        in_reset = 1;
        reset = 1'b1;
        #1;
        check("async_rst_d_oe", {31'd0, D_OE}, 0);
        check("async_rst_dtack", {31'd0, nDTACK_OE}, 0);
        check("async_rst_berr", {31'd0, nBERR_OE}, 0);
        nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge sys_clk);
        in_reset = 0;
        bus(24'hE90002, 1, 0, 0, 16'h0, 1, 0, mk(0, 1, 16'h0000, 0, 3'd0, 16'h0000));

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
